// File: rtl/enemy_control.sv
`default_nettype none
// ============================================================================
// Module      : enemy_control
// Description : Moore control FSM for one enemy sprite. Spawns the enemy at a
//               new column, draws its 4x4 sprite, waits a few slow ticks,
//               erases it and moves it down a row. Bullet hits cause an
//               erase-and-respawn; reaching the bottom row pulses `escaped`.
//               Optional feature macro: ENEMY_SPEEDUP_EN (each hit-respawn
//               shortens the WAIT dwell, an escape restores it).
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_control #(
  parameter int WAIT_TICKS   = 1,
  parameter int BOTTOM_STEPS = 116
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic       hit,
  input  logic [3:0] cnt,
  input  logic [3:0] delay_cnt,
  output logic       loadX,
  output logic       loadY,
  output logic       load_colour,
  output logic       load_black,
  output logic       en_counter,
  output logic       en_delay_counter,
  output logic       reset_delay,
  output logic       plot,
  output logic       escaped,
  output logic       respawned
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPAWN  = 3'd1,
    S_COLOUR = 3'd2,
    S_DRAW   = 3'd3,
    S_WAIT   = 3'd4,
    S_ERASE  = 3'd5,
    S_MOVE   = 3'd6
  } state_t;

  localparam logic [6:0] c_last_step  = 7'(BOTTOM_STEPS - 1);
  localparam logic [3:0] c_wait_ticks = 4'(WAIT_TICKS);
  localparam logic [3:0] c_last_pixel = 4'd15;

  state_t     state_q, state_d;
  logic [6:0] step_q, step_d;
  logic       hit_pending_q, hit_pending_d;

  logic       w_last_pixel;
  logic       w_at_bottom;
  logic [3:0] w_wait_lim;

  assign w_last_pixel = (cnt == c_last_pixel);
  assign w_at_bottom  = (step_q == c_last_step);

`ifdef ENEMY_SPEEDUP_EN
  logic [3:0] wait_lim_q, wait_lim_d;

  assign w_wait_lim = wait_lim_q;

  // Dwell limit: shrinks on every hit-driven respawn (floor 1), restored on escape.
  always_comb begin
    wait_lim_d = wait_lim_q;
    if (state_q == S_ERASE && w_last_pixel && go && hit_pending_q) begin
      wait_lim_d = (wait_lim_q > 4'd1) ? (wait_lim_q - 4'd1) : 4'd1;
    end else if (state_q == S_MOVE && w_at_bottom) begin
      wait_lim_d = c_wait_ticks;
    end
  end

  // Dwell limit register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_lim_q <= c_wait_ticks;
    end else begin
      wait_lim_q <= wait_lim_d;
    end
  end
`else
  assign w_wait_lim = c_wait_ticks;
`endif

  // State, row-step and pending-hit registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      step_q        <= 7'd0;
      hit_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      hit_pending_q <= hit_pending_d;
    end
  end

  // Next-state logic, hit capture and state-decoded Moore outputs.
  always_comb begin
    state_d          = state_q;
    step_d           = step_q;
    hit_pending_d    = hit_pending_q;
    loadX            = 1'b0;
    loadY            = 1'b0;
    load_colour      = 1'b0;
    load_black       = 1'b0;
    en_counter       = 1'b0;
    en_delay_counter = 1'b0;
    reset_delay      = 1'b1;
    plot             = 1'b0;
    escaped          = 1'b0;
    respawned        = 1'b0;

    // A hit is only remembered while the sprite is on screen or being drawn.
    if (hit && (state_q == S_DRAW || state_q == S_WAIT || state_q == S_ERASE)) begin
      hit_pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        reset_delay = 1'b0;
        if (go) begin
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        loadX         = 1'b1;
        reset_delay   = 1'b0;
        respawned     = 1'b1;
        step_d        = 7'd0;
        hit_pending_d = 1'b0;
        state_d       = S_COLOUR;
      end
      S_COLOUR: begin
        load_colour = 1'b1;
        state_d     = S_DRAW;
      end
      S_DRAW: begin
        plot       = 1'b1;
        en_counter = 1'b1;
        // The sprite is always finished before anything else is considered.
        if (w_last_pixel) begin
          state_d = hit_pending_q ? S_ERASE : S_WAIT;
        end
      end
      S_WAIT: begin
        en_delay_counter = 1'b1;
        if (hit || !go || (delay_cnt == w_wait_lim)) begin
          state_d = S_ERASE;
        end
      end
      S_ERASE: begin
        plot       = 1'b1;
        en_counter = 1'b1;
        load_black = 1'b1;
        if (w_last_pixel) begin
          if (!go) begin
            state_d = S_IDLE;
          end else if (hit_pending_q) begin
            state_d = S_SPAWN;
          end else begin
            state_d = S_MOVE;
          end
        end
      end
      S_MOVE: begin
        loadY       = 1'b1;
        reset_delay = 1'b0;
        escaped     = w_at_bottom;
        // step never exceeds BOTTOM_STEPS, so the increment cannot wrap.
        step_d      = step_q + 7'd1;
        state_d     = w_at_bottom ? S_SPAWN : S_DRAW;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_enemy_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_control
// Description : Self-checking bench for enemy_control. Emulates the enemy
//               datapath counters and compares every cycle's outputs against
//               a phase/duration model of the enemy's life cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_control;

  localparam int WT = 2;
  localparam int BS = 3;

  // Model phases (bench-local numbering).
  localparam int P_IDLE = 0, P_SPAWN = 1, P_COLOUR = 2, P_DRAW = 3;
  localparam int P_WAIT = 4, P_ERASE = 5, P_MOVE = 6;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       hit = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [3:0] delay_cnt = 4'd0;
  logic       loadX, loadY, load_colour, load_black, en_counter;
  logic       en_delay_counter, reset_delay, plot, escaped, respawned;

  enemy_control #(.WAIT_TICKS(WT), .BOTTOM_STEPS(BS)) dut (
    .clock(clock), .resetn(resetn), .go(go), .hit(hit), .cnt(cnt),
    .delay_cnt(delay_cnt), .loadX(loadX), .loadY(loadY),
    .load_colour(load_colour), .load_black(load_black),
    .en_counter(en_counter), .en_delay_counter(en_delay_counter),
    .reset_delay(reset_delay), .plot(plot), .escaped(escaped),
    .respawned(respawned)
  );

  always #5 clock = ~clock;

  wire [9:0] dut_vec = {loadX, loadY, load_colour, load_black, en_counter,
                        en_delay_counter, reset_delay, plot, escaped, respawned};

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int m_phase = P_IDLE;
  int m_pix   = 0;   // cycles already spent in the current DRAW/ERASE
  int m_wait  = 0;   // cycles already spent in WAIT
  int m_step  = 0;   // rows moved since the last spawn
  bit m_pend  = 0;
  int m_lim   = WT;
  int m_escapes = 0, d_escapes = 0;
  int m_spawns  = 0, d_spawns  = 0;

  // Expected output vector for the current phase.
  function automatic logic [9:0] expect_vec();
    case (m_phase)
      P_SPAWN:  return 10'b1000000001;
      P_COLOUR: return 10'b0010001000;
      P_DRAW:   return 10'b0000101100;
      P_WAIT:   return 10'b0000011000;
      P_ERASE:  return 10'b0001101100;
      P_MOVE:   return (m_step == BS - 1) ? 10'b0100000010 : 10'b0100000000;
      default:  return 10'b0000000000;
    endcase
  endfunction

  // Advance the model by one clock given the inputs seen at that edge.
  task automatic model_step(input logic g, input logic h, input logic r);
    bit old_pend;
    old_pend = m_pend;
    if (!r) begin
      m_phase = P_IDLE; m_step = 0; m_pend = 0; m_pix = 0; m_lim = WT;
      return;
    end
    if (h && (m_phase == P_DRAW || m_phase == P_WAIT || m_phase == P_ERASE)) m_pend = 1;
    case (m_phase)
      P_IDLE:   if (g) m_phase = P_SPAWN;
      P_SPAWN:  begin m_step = 0; m_pend = 0; m_phase = P_COLOUR; end
      P_COLOUR: begin m_phase = P_DRAW; m_pix = 0; end
      P_DRAW: begin
        if (m_pix == 15) begin
          m_phase = old_pend ? P_ERASE : P_WAIT;
          m_pix = 0; m_wait = 0;
        end else m_pix++;
      end
      P_WAIT: begin
        if (h || !g || m_wait == m_lim) begin m_phase = P_ERASE; m_pix = 0; end
        else m_wait++;
      end
      P_ERASE: begin
        if (m_pix == 15) begin
          m_pix = 0;
          if (!g) m_phase = P_IDLE;
          else if (old_pend) begin
            m_phase = P_SPAWN;
`ifdef ENEMY_SPEEDUP_EN
            m_lim = (m_lim > 1) ? m_lim - 1 : 1;
`endif
          end else m_phase = P_MOVE;
        end else m_pix++;
      end
      P_MOVE: begin
        if (m_step == BS - 1) begin
          m_phase = P_SPAWN; m_escapes++; m_lim = WT;
        end else m_phase = P_DRAW;
        m_pix = 0;
        m_step++;
      end
      default: m_phase = P_IDLE;
    endcase
    if (m_phase == P_SPAWN) m_spawns++;
  endtask

  // One clock: check outputs, apply inputs, emulate datapath, advance model.
  task automatic cycle(input logic g, input logic h, input logic r);
    logic [3:0] cn, dn;
    logic [9:0] ev;
    go = g; hit = h; resetn = r;
    ev = expect_vec();
    checks++;
    assert (dut_vec === ev) else begin
      errors++;
      $error("FAIL outputs phase=%0d pix=%0d obs=%b exp=%b", m_phase, m_pix, dut_vec, ev);
    end
    if (escaped === 1'b1) d_escapes++;
    if (respawned === 1'b1) d_spawns++;
    if (!r) begin
      cn = 4'd0; dn = 4'd0;
    end else begin
      cn = en_counter ? cnt + 4'd1 : cnt;
      dn = !reset_delay ? 4'd0 : (en_delay_counter ? delay_cnt + 4'd1 : delay_cnt);
    end
    model_step(g, h, r);
    @(posedge clock);
    #1;
    cnt = cn; delay_cnt = dn;
  endtask

  // Run with go=1 until the model reaches a phase (and pixel, if px>=0).
  task automatic run_until(input int ph, input int px, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_phase == ph && (px < 0 || m_pix == px)) begin found = 1; break; end
      cycle(1'b1, 1'b0, 1'b1);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL reach_phase phase=%0d pix=%0d obs=%0d exp=%0d", ph, px, m_phase, ph);
    end
  endtask

  initial begin
    // Reset: hold resetn low across two edges.
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    assert (dut_vec === 10'b0000000000) else begin
      errors++;
      $error("FAIL reset_outputs obs=%b exp=%b", dut_vec, 10'b0);
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Clean run: several steps, including escapes at the bottom.
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, 1'b1);

    // Hit at DRAW pixel 5: draw completes, erase, respawn without a move.
    run_until(P_DRAW, 5, 200);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) cycle(1'b1, 1'b0, 1'b1);

    // Hit coinciding with the last WAIT tick.
    run_until(P_WAIT, -1, 200);
    for (int i = 0; i < WT; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b1);

    // go dropped in WAIT together with a hit: erase then idle.
    run_until(P_WAIT, -1, 200);
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1);

    // Reset at DRAW pixel 8.
    run_until(P_DRAW, 8, 200);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Random hits with go steady.
    for (int i = 0; i < 800; i++)
      cycle(1'b1, ($urandom_range(0, 19) == 0), 1'b1);

    // Random hits, go drops and occasional resets.
    for (int i = 0; i < 1200; i++)
      cycle(($urandom_range(0, 24) != 0), ($urandom_range(0, 14) == 0),
            ($urandom_range(0, 149) != 0));

    // Pulse totals seen on the DUT pins versus the model's event counts.
    checks++;
    assert (d_escapes === m_escapes) else begin
      errors++;
      $error("FAIL escape_count obs=%0d exp=%0d", d_escapes, m_escapes);
    end
    checks++;
    assert (d_spawns === m_spawns) else begin
      errors++;
      $error("FAIL respawn_count obs=%0d exp=%0d", d_spawns, m_spawns);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
